// File: rtl/ram32_dp_fifo_pkg.sv
// Shared types and helpers for the 32-deep dual-port RAM FIFO.
// Provides the address/pointer widths, depth, pointer type and pointer increment.
package ram32_dp_fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 5;
  localparam int unsigned FIFO_DEPTH  = 32;
  localparam int unsigned PTR_W       = FIFO_ADDR_W + 1;

  // 5-bit RAM address plus one wrap bit
  typedef logic [PTR_W-1:0] ptr_t;

  // Advance a pointer; address 31 rolls to 0 and the wrap bit toggles naturally
  function automatic ptr_t ptr_inc(input ptr_t p);
    return ptr_t'(p + PTR_W'(1));
  endfunction

endpackage

// File: rtl/dpram32_slice.sv
// 32x1 dual-port distributed RAM slice.
// Ports:
//   CLK    - rising-edge write clock
//   i_we   - write enable
//   i_wa   - write address
//   i_d    - write data bit
//   i_ra   - independent read address
//   o_q_c  - asynchronous read data (combinational)
module dpram32_slice
  import ram32_dp_fifo_pkg::*;
(
  input  logic                   CLK,
  input  logic                   i_we,
  input  logic [FIFO_ADDR_W-1:0] i_wa,
  input  logic                   i_d,
  input  logic [FIFO_ADDR_W-1:0] i_ra,
  output logic                   o_q_c
);

  // Storage is intentionally not reset
  logic [FIFO_DEPTH-1:0] r_mem;

  // Synchronous write port
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_wa] <= i_d;
    end
  end

  // Asynchronous read port
  assign o_q_c = r_mem[i_ra];

endmodule

// File: rtl/ram32_dp_fifo.sv
// 32-deep synchronous FIFO built from WIDTH dual-port distributed RAM slices.
// Ports:
//   CLK       - rising-edge clock
//   RST       - asynchronous active-high reset
//   I         - write data
//   WE        - write request, accepted when FULL=0
//   RE        - read request, accepted when EMPTY=0
//   O         - registered read data, holds when no read is accepted
//   O_VALID   - one-cycle pulse when O carries newly popped data
//   FULL      - 32 entries stored
//   EMPTY     - no entries stored
//   COUNT     - occupancy 0..32
//   OVERFLOW  - sticky, WE seen while FULL
//   UNDERFLOW - sticky, RE seen while EMPTY
module ram32_dp_fifo
  import ram32_dp_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter              LOC   = "UNPLACED"
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             WE,
  input  logic             RE,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic [PTR_W-1:0] COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  // Placement attribute has no functional effect
  logic w_unused_loc;
  assign w_unused_loc = ^LOC;

  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  logic [WIDTH-1:0] r_o;
  logic             r_o_valid;
  logic             r_full;
  logic             r_empty;
  logic [PTR_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  ptr_t             w_wr_ptr_nxt;
  ptr_t             w_rd_ptr_nxt;
  logic             w_full_nxt;
  logic             w_empty_nxt;
  logic [PTR_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_rd_data;

  // Accept decisions use the registered flags, so a full FIFO rejects a write
  // even when a read frees a slot on the same edge (and vice versa for empty).
  always_comb begin
    w_wr_acc     = WE & ~r_full;
    w_rd_acc     = RE & ~r_empty;
    w_wr_ptr_nxt = w_wr_acc ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_acc ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_full_nxt   = (w_wr_ptr_nxt[FIFO_ADDR_W-1:0] == w_rd_ptr_nxt[FIFO_ADDR_W-1:0]) &&
                   (w_wr_ptr_nxt[FIFO_ADDR_W] != w_rd_ptr_nxt[FIFO_ADDR_W]);
    w_count_nxt  = PTR_W'(w_wr_ptr_nxt - w_rd_ptr_nxt);
  end

  // One RAM slice per data bit
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    dpram32_slice u_slice (
      .CLK   (CLK),
      .i_we  (w_wr_acc),
      .i_wa  (r_wr_ptr[FIFO_ADDR_W-1:0]),
      .i_d   (I[g]),
      .i_ra  (r_rd_ptr[FIFO_ADDR_W-1:0]),
      .o_q_c (w_rd_data[g])
    );
  end

  // Pointers, flags and output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_o         <= '0;
      r_o_valid   <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_o_valid   <= w_rd_acc;
      r_full      <= w_full_nxt;
      r_empty     <= w_empty_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= r_overflow | (WE & r_full);
      r_underflow <= r_underflow | (RE & r_empty);
      if (w_rd_acc) begin
        r_o <= w_rd_data;
      end
    end
  end

  assign O         = r_o;
  assign O_VALID   = r_o_valid;
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign COUNT     = r_count;
  assign OVERFLOW  = r_overflow;
  assign UNDERFLOW = r_underflow;

endmodule
